// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host transmitter state encoding, command bytes,
// and the frame parity helper. Used by the host transmitter and the
// scan-code receiver that sits on the same pins.
package ps2_pkg;

  // Host-to-device transmitter states.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INHIBIT   = 3'd1,
    ST_REQ       = 3'd2,
    ST_SEND      = 3'd3,
    ST_ACK       = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } ps2_host_tx_state_t;

  // Common keyboard command bytes and the device acknowledge code.
  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
  localparam logic [7:0] PS2_ACK          = 8'hFA;

  // Bits the device clocks in per host frame: data, parity, stop.
  localparam int PS2_TX_LAST_BIT = 10;

  // PS/2 frames carry odd parity: data bits plus parity hold an odd
  // number of ones.
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// Purpose : 2-FF synchroniser + FILTER_LEN-sample debounce for the PS/2 clock,
//           with a one-cycle pulse on each filtered falling edge.
// Latency : filtered level / fall pulse follow the pin by 2 + FILTER_LEN clk.
// Backpr. : none; free-running conditioning stage.
// Ports   : clk, reset (sync, active-high), ps2c_in (async pin readback),
//           ps2c (filtered level), fall (1-cycle pulse on filtered 1->0).
module ps2_clk_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic ps2c_in,
  output logic ps2c,
  output logic fall
);

  localparam int CW = $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

  logic [1:0]    c_sync;  // c_sync[1] is the metastability-safe sample
  logic [CW-1:0] cnt;     // consecutive samples disagreeing with ps2c

  // The idle bus level is high, so the synchroniser and filter come out of
  // reset at 1; otherwise the first sample would look like a falling edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      c_sync <= 2'b11;
      ps2c   <= 1'b1;
      cnt    <= '0;
      fall   <= 1'b0;
    end else begin
      c_sync <= {c_sync[0], ps2c_in};
      fall   <= 1'b0;
      if (c_sync[1] == ps2c) begin
        // Any agreeing sample restarts the run, so short glitches vanish.
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        // This is the FILTER_LEN-th disagreeing sample in a row.
        ps2c <= c_sync[1];
        cnt  <= '0;
        fall <= ~c_sync[1];
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_host_tx.sv
// Purpose : host-to-device PS/2 transmitter; sends one command byte over the
//           open-drain clock/data pins and checks the device ACK.
// Latency : INHIBIT_CYCLES + 1 request cycle, then 11 device clocks + line idle.
// Backpr. : tx_start honoured only while idle (tx_busy=0); otherwise dropped.
// Ports   : clk, reset (sync, active-high); tx_data/tx_start command request;
//           ps2c_in/ps2d_in async pin readback; ps2c_oe/ps2d_oe pull-low
//           enables; tx_busy level; tx_done/tx_error one-cycle result pulses.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1_000_000,
  parameter int FILTER_LEN     = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  input  logic       ps2c_in,
  input  logic       ps2d_in,
  output logic       ps2c_oe,
  output logic       ps2d_oe,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error
);

  // One counter serves both the inhibit interval and the per-edge timeout,
  // since they never run at the same time.
  localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES
                                                             : TIMEOUT_CYCLES;
  localparam int CNT_W = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]       LAST_BIT     = 4'(PS2_TX_LAST_BIT);

  ps2_host_tx_state_t state;
  logic [CNT_W-1:0]   cnt;
  logic [3:0]         bit_n;    // device clock falls seen in SEND, 0..10
  logic [7:0]         shift;    // unsent data bits, LSB next
  logic               parity;
  logic [1:0]         d_sync;
  logic               ps2d_s;
  logic               ps2c_filt;
  logic               ps2c_fall;
  logic               tmo_hit;

  ps2_clk_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_clk_filter (
    .clk     (clk),
    .reset   (reset),
    .ps2c_in (ps2c_in),
    .ps2c    (ps2c_filt),
    .fall    (ps2c_fall)
  );

  assign ps2d_s = d_sync[1];

  // A clock fall in the same cycle counts as activity and beats the timeout.
  assign tmo_hit = ((state == ST_SEND) || (state == ST_ACK) ||
                    (state == ST_WAIT_IDLE)) &&
                   !ps2c_fall && (cnt == TIMEOUT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      bit_n    <= '0;
      shift    <= '0;
      parity   <= 1'b0;
      d_sync   <= 2'b11;
      ps2c_oe  <= 1'b0;
      ps2d_oe  <= 1'b0;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
      tx_error <= 1'b0;
    end else begin
      d_sync   <= {d_sync[0], ps2d_in};
      tx_done  <= 1'b0;
      tx_error <= 1'b0;

      if (tmo_hit) begin
        // Device stopped clocking: let go of the bus and report.
        ps2c_oe  <= 1'b0;
        ps2d_oe  <= 1'b0;
        tx_error <= 1'b1;
        tx_busy  <= 1'b0;
        state    <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (tx_start) begin
              shift   <= tx_data;
              parity  <= odd_parity(tx_data);
              cnt     <= '0;
              ps2c_oe <= 1'b1;
              tx_busy <= 1'b1;
              state   <= ST_INHIBIT;
            end
          end

          ST_INHIBIT: begin
            if (cnt == INHIBIT_LAST) begin
              ps2d_oe <= 1'b1;  // start bit, clock still held low
              state   <= ST_REQ;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end

          ST_REQ: begin
            // Releasing the clock with data low is the request-to-send.
            ps2c_oe <= 1'b0;
            cnt     <= '0;
            bit_n   <= '0;
            state   <= ST_SEND;
          end

          ST_SEND: begin
            if (ps2c_fall) begin
              // Data moves right after a fall so it is stable well before
              // the device samples on the following rising edge.
              cnt   <= '0;
              bit_n <= bit_n + 1'b1;
              if (bit_n < 4'd8) begin
                ps2d_oe <= ~shift[0];
                shift   <= {1'b0, shift[7:1]};
              end else if (bit_n == 4'd8) begin
                ps2d_oe <= ~parity;
              end else if (bit_n + 1'b1 == LAST_BIT) begin
                ps2d_oe <= 1'b0;  // stop bit: released line reads 1
                state   <= ST_ACK;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end

          ST_ACK: begin
            if (ps2c_fall) begin
              cnt <= '0;
              if (!ps2d_s) begin
                state <= ST_WAIT_IDLE;
              end else begin
                tx_error <= 1'b1;
                tx_busy  <= 1'b0;
                state    <= ST_IDLE;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end

          ST_WAIT_IDLE: begin
            // The byte only counts as delivered once the device lets both
            // lines float high again.
            if (ps2c_fall) begin
              cnt <= '0;
            end else if (ps2c_filt && ps2d_s) begin
              tx_done <= 1'b1;
              tx_busy <= 1'b0;
              state   <= ST_IDLE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end

          default: begin
            ps2c_oe <= 1'b0;
            ps2d_oe <= 1'b0;
            tx_busy <= 1'b0;
            state   <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a PS/2 keyboard model on open-drain pins.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INHIBIT = 5000;
  localparam int TIMEOUT = 2000;
  localparam int HALF    = 20;   // device clock half period in clk cycles
  localparam int GAP     = 40;   // device delay after seeing the request

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       ps2c_oe, ps2d_oe, tx_busy, tx_done, tx_error;
  logic       dev_clk, dev_dat;
  logic       pin_c, pin_d;

  int n_assert = 0;
  int n_fail   = 0;

  // Monitor counters, updated with <= so the stimulus block sees stable values.
  int cyc = 0, done_cnt = 0, err_cnt = 0, both_cnt = 0;
  int inh_cnt = 0, req_cnt = 0, err_cyc = 0, rel_cyc = 0;
  logic prev_c = 1'b0;

  assign pin_c = ~ps2c_oe & dev_clk;
  assign pin_d = ~ps2d_oe & dev_dat;

  ps2_host_tx #(
    .INHIBIT_CYCLES (INHIBIT),
    .TIMEOUT_CYCLES (TIMEOUT),
    .FILTER_LEN     (8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .ps2c_in  (pin_c),
    .ps2d_in  (pin_d),
    .ps2c_oe  (ps2c_oe),
    .ps2d_oe  (ps2d_oe),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done),
    .tx_error (tx_error)
  );

  always #10 clk = ~clk;

  always @(negedge clk) begin
    cyc    <= cyc + 1;
    prev_c <= ps2c_oe;
    if (tx_done) done_cnt <= done_cnt + 1;
    if (tx_error) begin
      err_cnt <= err_cnt + 1;
      err_cyc <= cyc;
    end
    if (tx_done && tx_error) both_cnt <= both_cnt + 1;
    if (prev_c && !ps2c_oe) rel_cyc <= cyc;
    if (ps2c_oe && !ps2d_oe) inh_cnt <= inh_cnt + 1;
    if (ps2c_oe && ps2d_oe) req_cnt <= req_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_tx(input logic [7:0] b, input string tag);
    check({tag, "_idle_before"}, 32'(tx_busy), 32'd0);
    tx_data  = b;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    check({tag, "_busy_after_accept"}, 32'(tx_busy), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (tx_busy !== 1'b0 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_busy_drop"}, 32'(tx_busy), 32'd0);
    @(negedge clk);
  endtask

  // Keyboard model: waits for the request, samples the start bit, then
  // generates nclk clocks, sampling data at each rising edge. Clock 11 is the
  // ACK clock, with data pulled low when ack_low is set.
  task automatic dev_run(input string tag, input int nclk, input bit ack_low,
                         input int glitch_k, input int start_k,
                         output logic [10:0] frame);
    int n;
    frame = '0;
    n = 0;
    while (ps2c_oe !== 1'b0 && n < 8000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_clk_released"}, 32'(ps2c_oe), 32'd0);
    repeat (GAP) @(negedge clk);
    frame[0] = pin_d;
    for (int k = 1; k <= nclk; k++) begin
      if (k == 11 && ack_low) dev_dat = 1'b0;
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      dev_clk = 1'b1;
      if (k <= 10) frame[k] = pin_d;
      if (k == glitch_k) begin
        repeat (6) @(negedge clk);
        dev_clk = 1'b0;
        repeat (3) @(negedge clk);
        dev_clk = 1'b1;
        repeat (HALF - 9) @(negedge clk);
      end else if (k == start_k) begin
        tx_data  = 8'h00;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        repeat (HALF - 1) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
    end
    dev_dat = 1'b1;
  endtask

  initial begin
    logic [10:0] frame;
    int d0, e0, i0, r0, n;

    reset    = 1'b1;
    tx_start = 1'b0;
    tx_data  = 8'h00;
    dev_clk  = 1'b1;
    dev_dat  = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_ps2c_oe",  32'(ps2c_oe),  32'd0);
    check("rst_ps2d_oe",  32'(ps2d_oe),  32'd0);
    check("rst_tx_busy",  32'(tx_busy),  32'd0);
    check("rst_tx_done",  32'(tx_done),  32'd0);
    check("rst_tx_error", 32'(tx_error), 32'd0);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check("idle_after_reset", 32'({ps2c_oe, ps2d_oe, tx_busy, tx_done, tx_error}), 32'd0);

    // 1: set-LEDs command, full handshake with ACK
    d0 = done_cnt; e0 = err_cnt; i0 = inh_cnt; r0 = req_cnt;
    start_tx(PS2_CMD_SET_LEDS, "t1");
    dev_run("t1", 11, 1'b1, 0, 0, frame);
    check("t1_frame", 32'(frame), 32'({1'b1, 1'b1, 8'hED, 1'b0}));
    wait_idle("t1");
    check("t1_inhibit_cycles", 32'(inh_cnt - i0), 32'd5000);
    check("t1_req_cycles",     32'(req_cnt - r0), 32'd1);
    check("t1_done_pulses",    32'(done_cnt - d0), 32'd1);
    check("t1_error_pulses",   32'(err_cnt - e0), 32'd0);
    check("t1_lines_released", 32'({ps2c_oe, ps2d_oe}), 32'd0);

    // 2: parity of 0x01 is 0, of 0x00 is 1
    d0 = done_cnt;
    start_tx(8'h01, "t2a");
    dev_run("t2a", 11, 1'b1, 0, 0, frame);
    check("t2a_frame", 32'(frame), 32'({1'b1, 1'b0, 8'h01, 1'b0}));
    wait_idle("t2a");
    start_tx(8'h00, "t2b");
    dev_run("t2b", 11, 1'b1, 0, 0, frame);
    check("t2b_frame", 32'(frame), 32'({1'b1, 1'b1, 8'h00, 1'b0}));
    wait_idle("t2b");
    check("t2_done_pulses", 32'(done_cnt - d0), 32'd2);

    // 3: device never pulls data low on the ACK clock
    d0 = done_cnt; e0 = err_cnt;
    start_tx(PS2_CMD_ENABLE, "t3");
    dev_run("t3", 11, 1'b0, 0, 0, frame);
    check("t3_frame", 32'(frame), 32'({1'b1, 1'b0, 8'hF4, 1'b0}));
    wait_idle("t3");
    check("t3_error_pulses",   32'(err_cnt - e0), 32'd1);
    check("t3_done_pulses",    32'(done_cnt - d0), 32'd0);
    check("t3_lines_released", 32'({ps2c_oe, ps2d_oe}), 32'd0);

    // 4: device never clocks after the request
    d0 = done_cnt; e0 = err_cnt;
    start_tx(PS2_CMD_RESET, "t4");
    n = 0;
    while (err_cnt == e0 && n < INHIBIT + TIMEOUT + 200) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("t4_error_pulses",   32'(err_cnt - e0), 32'd1);
    check("t4_timeout_cycles", 32'(err_cyc - rel_cyc), 32'(TIMEOUT));
    check("t4_lines_released", 32'({ps2c_oe, ps2d_oe}), 32'd0);
    check("t4_busy",           32'(tx_busy), 32'd0);
    check("t4_done_pulses",    32'(done_cnt - d0), 32'd0);

    // 5: reset after the 4th device clock, then a clean transfer
    d0 = done_cnt; e0 = err_cnt;
    start_tx(8'hFF, "t5a");
    dev_run("t5a", 4, 1'b0, 0, 0, frame);
    check("t5_data_driven_before_reset", 32'(ps2d_oe), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("t5_rst_ps2c_oe", 32'(ps2c_oe), 32'd0);
    check("t5_rst_ps2d_oe", 32'(ps2d_oe), 32'd0);
    check("t5_rst_tx_busy", 32'(tx_busy), 32'd0);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check("t5_no_pulses_on_reset", 32'((done_cnt - d0) + (err_cnt - e0)), 32'd0);
    start_tx(PS2_CMD_ENABLE, "t5b");
    dev_run("t5b", 11, 1'b1, 0, 0, frame);
    check("t5b_frame", 32'(frame), 32'({1'b1, 1'b0, 8'hF4, 1'b0}));
    wait_idle("t5b");
    check("t5b_done_pulses", 32'(done_cnt - d0), 32'd1);

    // 6: tx_start mid-frame and a 3-cycle clock glitch must not disturb the byte
    d0 = done_cnt; e0 = err_cnt;
    start_tx(8'hA5, "t6");
    dev_run("t6", 11, 1'b1, 5, 3, frame);
    check("t6_frame", 32'(frame), 32'({1'b1, 1'b1, 8'hA5, 1'b0}));
    wait_idle("t6");
    check("t6_done_pulses",  32'(done_cnt - d0), 32'd1);
    check("t6_error_pulses", 32'(err_cnt - e0), 32'd0);

    check("done_and_error_overlap", 32'(both_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
